// File: rtl/cacheline_adaptor.sv
// Bridges whole-line (LINE_W) cache requests to BEATS-beat BURST_W memory bursts.
// One request in flight; read beats are gathered into line_o, write lines are sliced onto burst_o.
module cacheline_adaptor #(
  parameter int LINE_W   = 256,
  parameter int BURST_W  = 64,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                          state, state_nxt;
  logic [1:0]                      cnt;
  logic [1:0]                      cnt_inc;
  logic                            last_beat;
  logic [BEATS-1:0][BURST_W-1:0]   line_q;
  logic [BEATS-1:0][BURST_W-1:0]   wline_q;

  assign cnt_inc   = cnt + 2'd1;
  assign last_beat = resp_i && (cnt == LAST_BEAT);
  assign line_o    = line_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (write_i)     state_nxt = WRITE;
        else if (read_i) state_nxt = READ;
      end
      READ, WRITE: begin
        if (last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory-side strobes and beat datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 2'd0;
      line_q    <= '0;
      wline_q   <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
    end else begin
      resp_o  <= (state_nxt == DONE);
      read_o  <= (state_nxt == READ);
      write_o <= (state_nxt == WRITE);
      case (state)
        IDLE: begin
          if (write_i || read_i)
            address_o <= {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          if (write_i) begin
            wline_q <= line_i;
            burst_o <= line_i[BURST_W-1:0];
          end
        end
        READ: begin
          if (resp_i) begin
            line_q[cnt] <= burst_i;
            if (!last_beat) cnt <= cnt_inc;
          end
        end
        WRITE: begin
          // Counter holds at the final beat; it only wraps when DONE clears it.
          if (resp_i && !last_beat) begin
            cnt     <= cnt_inc;
            burst_o <= wline_q[cnt_inc];
          end
        end
        DONE:    cnt <= 2'd0;
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed plus randomized bench for cacheline_adaptor; a beat-level model
// predicts the gathered line, beat order on burst_o, and response timing.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_line = '0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  // Read burst. pat/pat_len give the resp_i sequence (LSB first, then 1s);
  // pat_len < 0 means random strobes. fixed selects fixed_beats as data.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] pat, input int pat_len,
                          input bit fixed, input logic [63:0] fixed_beats [4], input bit hold);
    logic [63:0] got [$];
    logic [255:0] exp_line;
    int cyc;
    logic r;
    address_i = addr;
    read_i    = 1'b1;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    step();
    chk("rd_addr", address_o, line_addr(addr));
    cyc = 0;
    while (got.size() < 4 && cyc < 64) begin
      if (pat_len < 0)        r = 1'($urandom_range(0, 1));
      else if (cyc < pat_len) r = pat[cyc];
      else                    r = 1'b1;
      burst_i = fixed ? fixed_beats[got.size()] : {$urandom, $urandom};
      resp_i  = r;
      address_i = $urandom;
      chk("rd_read_o", read_o, 1'b1);
      chk("rd_write_o", write_o, 1'b0);
      chk("rd_resp_early", resp_o, 1'b0);
      if (got.size() == 0) chk("rd_line_hold", line_o, last_line);
      if (r) got.push_back(burst_i);
      step();
      cyc++;
    end
    if (got.size() < 4) begin
      chk("rd_timeout", 256'(got.size()), 256'd4);
      return;
    end
    resp_i   = 1'b0;
    exp_line = {got[3], got[2], got[1], got[0]};
    chk("rd_resp", resp_o, 1'b1);
    chk("rd_read_drop", read_o, 1'b0);
    chk("rd_line", line_o, exp_line);
    last_line = exp_line;
    if (!hold) read_i = 1'b0;
    address_i = addr;
    step();
    chk("rd_resp_once", resp_o, 1'b0);
    chk("rd_idle_read_o", read_o, 1'b0);
    chk("rd_line_stable", line_o, exp_line);
  endtask

  // Write burst; line_i is scrambled every cycle after the request is taken.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input int pat_len, input logic [31:0] pat, input bit both);
    int acc;
    int cyc;
    logic r;
    logic [63:0] exp_beat;
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = both;
    resp_i    = 1'b0;
    step();
    chk("wr_addr", address_o, line_addr(addr));
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 64) begin
      line_i    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      address_i = $urandom;
      if (pat_len < 0)        r = 1'($urandom_range(0, 1));
      else if (cyc < pat_len) r = pat[cyc];
      else                    r = 1'b1;
      resp_i   = r;
      exp_beat = line[acc*64 +: 64];
      chk("wr_write_o", write_o, 1'b1);
      chk("wr_read_o", read_o, 1'b0);
      chk("wr_burst", burst_o, exp_beat);
      chk("wr_addr_hold", address_o, line_addr(addr));
      chk("wr_resp_early", resp_o, 1'b0);
      if (r) acc++;
      step();
      cyc++;
    end
    if (acc < 4) begin
      chk("wr_timeout", 256'(acc), 256'd4);
      return;
    end
    resp_i = 1'b0;
    chk("wr_resp", resp_o, 1'b1);
    chk("wr_write_drop", write_o, 1'b0);
    chk("wr_read_never", read_o, 1'b0);
    chk("wr_line_o_untouched", line_o, last_line);
    write_i = 1'b0;
    read_i  = 1'b0;
    step();
    chk("wr_resp_once", resp_o, 1'b0);
  endtask

  initial begin
    logic [63:0] fb [4];
    logic [63:0] none [4];
    logic [255:0] wl;
    for (int i = 0; i < 4; i++) none[i] = '0;
    fb[0] = {4{16'h1111}};
    fb[1] = {4{16'h2222}};
    fb[2] = {4{16'h3333}};
    fb[3] = {4{16'h4444}};

    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    #1;
    step();
    step();
    chk("rst_line_o", line_o, '0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_address_o", address_o, '0);
    chk("rst_burst_o", burst_o, '0);
    rst = 1'b0;

    // Strobes in IDLE must be ignored.
    resp_i = 1'b1; burst_i = {2{32'hDEADBEEF}};
    step();
    step();
    chk("idle_resp_ignored", line_o, '0);
    chk("idle_no_read", read_o, 1'b0);
    resp_i = 1'b0;

    run_read(32'h0000_1234, 32'hF, 4, 1'b1, fb, 1'b0);
    chk("rd_directed_line", line_o, {fb[3], fb[2], fb[1], fb[0]});

    run_read(32'hABCD_EF7F, 32'h69, 7, 1'b0, none, 1'b0);

    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    run_write(32'h8000_0041, wl, 8, 32'h5B, 1'b0);

    run_write(32'h0000_0FFF, {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom}, 0, 32'h0, 1'b1);

    // Reset after two accepted read beats.
    address_i = 32'h0000_2000; read_i = 1'b1; step();
    resp_i = 1'b1; burst_i = 64'h1; step();
    burst_i = 64'h2; step();
    resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
    step();
    chk("mid_rst_read_o", read_o, 1'b0);
    chk("mid_rst_line_o", line_o, '0);
    chk("mid_rst_resp_o", resp_o, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_resp_o", resp_o, 1'b0);
    chk("post_rst_read_o", read_o, 1'b0);
    last_line = '0;
    run_read(32'h0000_2040, 32'hF, 4, 1'b1, fb, 1'b0);

    // Back-to-back: first read held through DONE, second starts from beat 0.
    run_read(32'h1000_0000, 32'h0, -1, 1'b0, none, 1'b1);
    run_read(32'h1000_0020, 32'h0, -1, 1'b0, none, 1'b0);

    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 1) == 0)
        run_read($urandom, 32'h0, -1, 1'b0, none, 1'($urandom_range(0, 1)));
      else
        run_write($urandom, {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom}, -1, 32'h0, 1'b0);
      read_i = 1'b0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
